alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared combinational ALU.
// Each operation is accepted from one requester and latched into operand
// registers that drive the ALU. After EXEC_CYCLES edges the ALU output is
// captured and returned to the requester that issued the operation.
// When both requesters are valid, the one not served last wins the grant.
//
// Handshake rule used on every port pair:
//   A transfer happens on a rising CLK edge where VALID and READY are both
//   high. A source holds VALID and its payload steady until that edge.
//   READY is a combinational decision of the receiver for the current cycle.
module alu_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  // Request side
  input  logic        REQ0_VALID,
  input  logic        REQ1_VALID,
  output logic        REQ0_READY,
  output logic        REQ1_READY,
  input  logic [31:0] REQ0_DATA1,
  input  logic [31:0] REQ1_DATA1,
  input  logic [31:0] REQ0_DATA2,
  input  logic [31:0] REQ1_DATA2,
  input  logic [5:0]  REQ0_SELECT,
  input  logic [5:0]  REQ1_SELECT,
  // Response side
  output logic        RSP0_VALID,
  output logic        RSP1_VALID,
  input  logic        RSP0_READY,
  input  logic        RSP1_READY,
  output logic [31:0] RSP0_RESULT,
  output logic [31:0] RSP1_RESULT,
  // Shared ALU
  output logic [31:0] ALU_DATA1,
  output logic [31:0] ALU_DATA2,
  output logic [5:0]  ALU_SELECT,
  input  logic [31:0] ALU_RESULT,
  // Status
  output logic        BUSY,
  output logic [1:0]  DBG_STATE
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  logic [1:0]  state_q,  state_d;
  logic [31:0] op1_q,    op1_d;
  logic [31:0] op2_q,    op2_d;
  logic [5:0]  sel_q,    sel_d;
  logic [31:0] result_q, result_d;
  logic        tag_q,    tag_d;
  logic        last_q,   last_d;
  logic [3:0]  cnt_q,    cnt_d;

  logic        grant_any;
  logic        grant_id;
  logic        accept;
  logic        rsp_fire;

  // Grant decision: a lone valid requester wins, otherwise the one not served last.
  always_comb begin
    grant_any = REQ0_VALID | REQ1_VALID;
    if (REQ0_VALID && REQ1_VALID) begin
      grant_id = ~last_q;
    end else begin
      grant_id = REQ1_VALID;
    end
  end

  // Handshake strobes; READY is only offered in IDLE and is forced low in reset.
  always_comb begin
    REQ0_READY = RESET_N && (state_q == ST_IDLE) && grant_any && !grant_id;
    REQ1_READY = RESET_N && (state_q == ST_IDLE) && grant_any &&  grant_id;
    accept     = REQ0_READY | REQ1_READY;
    rsp_fire   = (state_q == ST_RESP) && (tag_q ? RSP1_READY : RSP0_READY);
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    sel_d    = sel_q;
    result_d = result_q;
    tag_d    = tag_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op1_d   = grant_id ? REQ1_DATA1  : REQ0_DATA1;
          op2_d   = grant_id ? REQ1_DATA2  : REQ0_DATA2;
          sel_d   = grant_id ? REQ1_SELECT : REQ0_SELECT;
          tag_d   = grant_id;
          cnt_d   = CNT_LOAD;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d = ALU_RESULT;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_fire) begin
          last_d  = tag_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      op1_q    <= 32'd0;
      op2_q    <= 32'd0;
      sel_q    <= 6'd0;
      result_q <= 32'd0;
      tag_q    <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      tag_q    <= tag_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output drive: ALU straight from operand registers, response steered by tag.
  always_comb begin
    ALU_DATA1   = op1_q;
    ALU_DATA2   = op2_q;
    ALU_SELECT  = sel_q;
    RSP0_VALID  = (state_q == ST_RESP) && !tag_q;
    RSP1_VALID  = (state_q == ST_RESP) &&  tag_q;
    RSP0_RESULT = RSP0_VALID ? result_q : 32'd0;
    RSP1_RESULT = RSP1_VALID ? result_q : 32'd0;
    BUSY        = (state_q != ST_IDLE);
    DBG_STATE   = state_q;
  end

endmodule
